// File: rtl/shift_reg_ctrl.sv
// Sequencer feeding a shift_reg: valid/ready word in, one LOAD cycle, then N shift enables.
// Optional back-to-back mode (1-entry pending buffer) enabled by defining SHIFT_CTRL_B2B_EN.
module shift_reg_ctrl #(
    parameter int   N    = 4,
    parameter logic FILL = 1'b0
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         stall,
    input  logic         flush,
    output logic         ser_load_en,
    output logic [N-1:0] ser_load,
    output logic         ser_en,
    output logic         ser_din,
    output logic         busy,
    output logic         done
);

    localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  hold;
    logic          accept;
    logic          last_shift;

`ifdef SHIFT_CTRL_B2B_EN
    logic          pend;
    logic [N-1:0]  next_q;

    // A second word may only be taken while shifting and the buffer is empty.
    assign in_ready = !flush && ((state == IDLE) || ((state == SHIFT) && !pend));
`else
    assign in_ready = !flush && (state == IDLE);
`endif

    assign accept     = in_valid && in_ready;
    assign last_shift = (state == SHIFT) && !stall && (cnt == CW'(N - 1));

    assign ser_load_en = (state == LOAD);
    assign ser_load    = hold;
    assign ser_en      = (state == SHIFT) && !stall;
    assign ser_din     = FILL;
    assign busy        = (state != IDLE);
    assign done        = last_shift && !flush;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state_nxt = LOAD;
                end
                LOAD: begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end
                SHIFT: begin
                    if (!stall) cnt_nxt = cnt + 1'b1;
                    if (last_shift) begin
                        cnt_nxt = '0;
`ifdef SHIFT_CTRL_B2B_EN
                        state_nxt = (pend || accept) ? LOAD : IDLE;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // hold only changes on entry to LOAD, so ser_load is stable through SHIFT.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            hold <= '0;
        end else if ((state == IDLE) && accept) begin
            hold <= in_data;
`ifdef SHIFT_CTRL_B2B_EN
        end else if (last_shift && !flush && pend) begin
            hold <= next_q;
        end else if (last_shift && accept) begin
            hold <= in_data;
`endif
        end
    end

`ifdef SHIFT_CTRL_B2B_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pend <= 1'b0;
        end else if (flush || last_shift) begin
            pend <= 1'b0;
        end else if ((state == SHIFT) && accept) begin
            pend <= 1'b1;
        end
    end

    // NOTE: payload-only register left without reset; pend qualifies its contents.
    always_ff @(posedge clk) begin
        if ((state == SHIFT) && accept) next_q <= in_data;
    end
`endif

endmodule
